// File: rtl/pong_engine_if.sv
// Video-side and player-side signals of the Pong engine, bundled for port use.
interface pong_engine_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       blank;
  logic       VS;
  logic       btn_l_up;
  logic       btn_l_dn;
  logic       btn_r_up;
  logic       btn_r_dn;
  logic [2:0] rgb;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  modport master (
    output x, y, blank, VS, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    input  rgb, score_l, score_r, game_over
  );

  modport slave (
    input  x, y, blank, VS, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn,
    output rgb, score_l, score_r, game_over
  );
endinterface

// File: rtl/pong_engine.sv
// Two-player Pong: game state steps once per frame on the VS falling edge; colour is registered every CLK.
// Optional macro PONG_RIGHT_AI_EN: the right paddle tracks the ball instead of following its buttons.
module pong_engine #(
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_STEP  = 6,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input logic          CLK,
  input logic          RST,
  pong_engine_if.slave bus
);
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, SCORE = 2'd2, GAME_OVER = 2'd3} state_t;

  localparam logic [10:0] PH      = 11'(PADDLE_H);
  localparam logic [10:0] PW      = 11'(PADDLE_W);
  localparam logic [10:0] SZ      = 11'(BALL_SIZE);
  localparam logic [10:0] SPD     = 11'(BALL_SPEED);
  localparam logic [10:0] STEP    = 11'(PADDLE_STEP);
  localparam logic [10:0] FIELD_H = 11'd480;
  localparam logic [10:0] FIELD_W = 11'd640;
  localparam logic [10:0] PAD_MAX = FIELD_H - PH;
  localparam logic [10:0] PAD_MID = 11'(PADDLE_H / 2);
  localparam logic [10:0] BALL_MID = 11'(BALL_SIZE / 2);
  localparam logic [10:0] L_X     = 11'd16;
  localparam logic [10:0] R_X     = 11'd616;
  localparam logic [10:0] L_FACE  = L_X + PW;
  localparam logic [10:0] BX0     = 11'd316;
  localparam logic [10:0] BY0     = 11'd236;
  localparam logic [10:0] PAD0    = 11'd208;
  localparam logic [10:0] NET_L   = 11'd318;
  localparam logic [10:0] NET_R   = 11'd321;
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
  localparam logic [7:0]  CNT_LAST = 8'(PAUSE_FRAMES - 1);

  state_t      state, state_n;
  logic [10:0] pl, pr, bx, by;
  logic [10:0] pl_n, pr_n, bx_n, by_n;
  logic        dx, dy, dx_n, dy_n;
  logic [3:0]  sc_l, sc_r, sc_l_n, sc_r_n;
  logic [7:0]  cnt, cnt_n;
  logic        vs_q, tick;
  logic        r_up, r_dn;
  logic        hit_l, hit_r;
  logic [2:0]  rgb_q, rgb_n;
  logic [10:0] px, py;
  logic        in_ball, in_pad, in_net;

  function automatic logic [10:0] pad_next(input logic [10:0] p, input logic up, input logic dn);
    if (up && !dn) return (p < STEP) ? 11'd0 : p - STEP;
    if (dn && !up) return (p + STEP > PAD_MAX) ? PAD_MAX : p + STEP;
    return p;
  endfunction

  assign tick = vs_q & ~bus.VS;

`ifdef PONG_RIGHT_AI_EN
  assign r_up = (by + BALL_MID) < (pr + PAD_MID);
  assign r_dn = (by + BALL_MID) > (pr + PAD_MID);
`else
  assign r_up = bus.btn_r_up;
  assign r_dn = bus.btn_r_dn;
`endif

  // Paddle overlap is judged against the pre-tick ball row and paddle tops.
  assign hit_l = (by + SZ > pl) && (by < pl + PH);
  assign hit_r = (by + SZ > pr) && (by < pr + PH);

  always_comb begin
    state_n = state;
    pl_n    = pl;
    pr_n    = pr;
    bx_n    = bx;
    by_n    = by;
    dx_n    = dx;
    dy_n    = dy;
    sc_l_n  = sc_l;
    sc_r_n  = sc_r;
    cnt_n   = cnt;
    if (tick && state != GAME_OVER) begin
      pl_n = pad_next(pl, bus.btn_l_up, bus.btn_l_dn);
      pr_n = pad_next(pr, r_up, r_dn);
    end
    if (tick) begin
      case (state)
        SERVE: begin
          bx_n    = BX0;
          by_n    = BY0;
          state_n = PLAY;
        end
        PLAY: begin
          if (!dy) begin
            if (by < SPD) begin
              by_n = 11'd0;
              dy_n = 1'b1;
            end else begin
              by_n = by - SPD;
            end
          end else if (by + SZ + SPD > FIELD_H) begin
            by_n = FIELD_H - SZ;
            dy_n = 1'b0;
          end else begin
            by_n = by + SPD;
          end
          // bx <= L_FACE + SPD is bx - SPD <= L_FACE without unsigned underflow.
          if (!dx) begin
            if (bx <= L_FACE + SPD && hit_l) begin
              bx_n = L_FACE;
              dx_n = 1'b1;
            end else if (bx < SPD) begin
              sc_r_n  = sc_r + 4'd1;
              dx_n    = 1'b0;
              state_n = SCORE;
            end else begin
              bx_n = bx - SPD;
            end
          end else begin
            if (bx + SZ + SPD >= R_X && hit_r) begin
              bx_n = R_X - SZ;
              dx_n = 1'b0;
            end else if (bx + SZ + SPD > FIELD_W) begin
              sc_l_n  = sc_l + 4'd1;
              dx_n    = 1'b1;
              state_n = SCORE;
            end else begin
              bx_n = bx + SPD;
            end
          end
        end
        SCORE: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = 8'd0;
            state_n = (sc_l == WIN || sc_r == WIN) ? GAME_OVER : SERVE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign px = {1'b0, bus.x};
  assign py = {1'b0, bus.y};

  always_comb begin
    in_ball = (px >= bx) && (px < bx + SZ) && (py >= by) && (py < by + SZ);
    in_pad  = ((px >= L_X) && (px < L_X + PW) && (py >= pl) && (py < pl + PH)) ||
              ((px >= R_X) && (px < R_X + PW) && (py >= pr) && (py < pr + PH));
    in_net  = (px >= NET_L) && (px <= NET_R) && !bus.y[4];
    if (bus.blank)               rgb_n = 3'b000;
    else if (in_ball)            rgb_n = 3'b110;
    else if (in_pad)             rgb_n = 3'b111;
    else if (in_net)             rgb_n = 3'b011;
    else if (state == GAME_OVER) rgb_n = 3'b100;
    else                         rgb_n = 3'b000;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= SERVE;
      pl    <= PAD0;
      pr    <= PAD0;
      bx    <= BX0;
      by    <= BY0;
      dx    <= 1'b1;
      dy    <= 1'b1;
      sc_l  <= 4'd0;
      sc_r  <= 4'd0;
      cnt   <= 8'd0;
      vs_q  <= 1'b1;
      rgb_q <= 3'b000;
    end else begin
      state <= state_n;
      pl    <= pl_n;
      pr    <= pr_n;
      bx    <= bx_n;
      by    <= by_n;
      dx    <= dx_n;
      dy    <= dy_n;
      sc_l  <= sc_l_n;
      sc_r  <= sc_r_n;
      cnt   <= cnt_n;
      vs_q  <= bus.VS;
      rgb_q <= rgb_n;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.score_l   = sc_l;
  assign bus.score_r   = sc_r;
  assign bus.game_over = (state == GAME_OVER);
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: pixel table at a known game state plus hand-traced rallies.
module tb_pong_engine;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  pong_engine_if bus();

  pong_engine dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic [2:0] rgb;
  } pix_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pix(input string name, input logic [9:0] px, input logic [9:0] py,
                     input logic pb, input logic [2:0] exp);
    bus.x     = px;
    bus.y     = py;
    bus.blank = pb;
    @(negedge CLK);
    chk(name, int'(bus.rgb), int'(exp));
  endtask

  // Runs n frame ticks with the given buttons held; returns at a negedge with VS high.
  task automatic frames(input int n, input logic lu, input logic ld, input logic ru, input logic rd);
    bus.btn_l_up = lu;
    bus.btn_l_dn = ld;
    bus.btn_r_up = ru;
    bus.btn_r_dn = rd;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) bus.VS = 1'b0;
      @(negedge CLK) bus.VS = 1'b1;
    end
    @(negedge CLK);
    bus.btn_l_up = 1'b0;
    bus.btn_l_dn = 1'b0;
    bus.btn_r_up = 1'b0;
    bus.btn_r_dn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rgb"}, int'(bus.rgb), 0);
    chk({tag, " score_l"}, int'(bus.score_l), 0);
    chk({tag, " score_r"}, int'(bus.score_r), 0);
    chk({tag, " game_over"}, int'(bus.game_over), 0);
    chk({tag, " pl"}, int'(dut.pl), 208);
    chk({tag, " pr"}, int'(dut.pr), 208);
    chk({tag, " bx"}, int'(dut.bx), 316);
    chk({tag, " by"}, int'(dut.by), 236);
    chk({tag, " state"}, int'(dut.state), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    pix_t tbl[18];
    tbl[0]  = '{10'd318, 10'd236, 1'b0, 3'b110};
    tbl[1]  = '{10'd318, 10'd236, 1'b1, 3'b000};
    tbl[2]  = '{10'd316, 10'd236, 1'b0, 3'b110};
    tbl[3]  = '{10'd323, 10'd243, 1'b0, 3'b110};
    tbl[4]  = '{10'd324, 10'd243, 1'b0, 3'b000};
    tbl[5]  = '{10'd318, 10'd0,   1'b0, 3'b011};
    tbl[6]  = '{10'd321, 10'd15,  1'b0, 3'b011};
    tbl[7]  = '{10'd322, 10'd0,   1'b0, 3'b000};
    tbl[8]  = '{10'd318, 10'd16,  1'b0, 3'b000};
    tbl[9]  = '{10'd16,  10'd208, 1'b0, 3'b111};
    tbl[10] = '{10'd23,  10'd271, 1'b0, 3'b111};
    tbl[11] = '{10'd24,  10'd208, 1'b0, 3'b000};
    tbl[12] = '{10'd16,  10'd272, 1'b0, 3'b000};
    tbl[13] = '{10'd616, 10'd240, 1'b0, 3'b111};
    tbl[14] = '{10'd623, 10'd208, 1'b0, 3'b111};
    tbl[15] = '{10'd615, 10'd208, 1'b0, 3'b000};
    tbl[16] = '{10'd319, 10'd32,  1'b0, 3'b011};
    tbl[17] = '{10'd16,  10'd208, 1'b1, 3'b000};

    RST = 1'b1;
    bus.x = 10'd0;
    bus.y = 10'd0;
    bus.blank = 1'b1;
    bus.VS = 1'b1;
    bus.btn_l_up = 1'b0;
    bus.btn_l_dn = 1'b0;
    bus.btn_r_up = 1'b0;
    bus.btn_r_dn = 1'b0;

    do_reset();
    chk_reset_state("rst0");

    // Serve tick, then pixel table against ball (316,236), paddles at 208.
    frames(1, 0, 0, 0, 0);
    chk("serve state", int'(dut.state), 1);
    for (int i = 0; i < 18; i++) begin
      bus.x     = tbl[i].x;
      bus.y     = tbl[i].y;
      bus.blank = tbl[i].blank;
      @(negedge CLK);
      chk($sformatf("pix%0d", i), int'(bus.rgb), int'(tbl[i].rgb));
    end
    bus.blank = 1'b1;

    frames(1, 0, 0, 0, 0);
    chk("flight bx", int'(dut.bx), 320);
    chk("flight by", int'(dut.by), 240);

    frames(40, 1, 0, 0, 1);
    chk("clamp pl", int'(dut.pl), 0);
    chk("clamp pr", int'(dut.pr), 416);
    chk("T42 bx", int'(dut.bx), 480);
    chk("T42 by", int'(dut.by), 400);
    frames(5, 1, 0, 0, 1);
    chk("clamp pl hold", int'(dut.pl), 0);
    chk("clamp pr hold", int'(dut.pr), 416);
    frames(16, 0, 1, 0, 0);
    chk("pl down", int'(dut.pl), 96);
    frames(4, 1, 1, 0, 0);
    chk("pl both", int'(dut.pl), 96);

    frames(6, 0, 0, 0, 0);
    chk("pre rhit bx", int'(dut.bx), 604);
    chk("pre rhit by", int'(dut.by), 424);
    chk("pre rhit dx", int'(dut.dx), 1);
    frames(1, 0, 0, 0, 0);
    chk("rhit bx", int'(dut.bx), 608);
    chk("rhit dx", int'(dut.dx), 0);
    chk("rhit by", int'(dut.by), 420);

    frames(145, 0, 0, 0, 0);
    chk("pre lhit bx", int'(dut.bx), 28);
    chk("pre lhit by", int'(dut.by), 156);
    frames(1, 0, 0, 0, 0);
    chk("lhit bx", int'(dut.bx), 24);
    chk("lhit dx", int'(dut.dx), 1);
    chk("lhit by", int'(dut.by), 160);

    frames(34, 0, 0, 1, 0);
    chk("pr up", int'(dut.pr), 212);
    frames(45, 0, 0, 0, 0);
    chk("bottom by", int'(dut.by), 472);
    chk("bottom dy", int'(dut.dy), 0);
    frames(66, 0, 0, 0, 0);
    chk("pre rhit2 bx", int'(dut.bx), 604);
    chk("pre rhit2 by", int'(dut.by), 208);
    frames(1, 0, 0, 0, 0);
    chk("rhit2 bx", int'(dut.bx), 608);
    chk("rhit2 dx", int'(dut.dx), 0);

    frames(51, 0, 0, 0, 0);
    chk("top by", int'(dut.by), 0);
    chk("top dy", int'(dut.dy), 0);
    frames(1, 0, 0, 0, 0);
    chk("top bounce by", int'(dut.by), 0);
    chk("top bounce dy", int'(dut.dy), 1);
    frames(1, 0, 0, 0, 0);
    chk("after top by", int'(dut.by), 4);
    chk("after top bx", int'(dut.bx), 396);

    frames(92, 0, 0, 0, 0);
    chk("pre lmiss bx", int'(dut.bx), 28);
    chk("pre lmiss by", int'(dut.by), 372);
    frames(1, 0, 0, 0, 0);
    chk("lmiss pass bx", int'(dut.bx), 24);
    chk("lmiss pass dx", int'(dut.dx), 0);
    frames(6, 0, 0, 0, 0);
    chk("edge bx", int'(dut.bx), 0);
    chk("edge score_r", int'(bus.score_r), 0);
    chk("edge state", int'(dut.state), 1);
    frames(1, 0, 0, 0, 0);
    chk("miss score_r", int'(bus.score_r), 1);
    chk("miss score_l", int'(bus.score_l), 0);
    chk("miss state", int'(dut.state), 2);
    chk("miss dx", int'(dut.dx), 0);

    // Mid-game reset, then let the left player score on every rally up to WIN_SCORE.
    do_reset();
    chk_reset_state("rst1");
    frames(80, 0, 0, 0, 0);
    chk("p1 pre bx", int'(dut.bx), 632);
    chk("p1 pre by", int'(dut.by), 396);
    chk("p1 pre score_l", int'(bus.score_l), 0);
    frames(1, 0, 0, 0, 0);
    chk("p1 score_l", int'(bus.score_l), 1);
    chk("p1 state", int'(dut.state), 2);
    chk("p1 dx", int'(dut.dx), 1);
    for (int p = 2; p <= 9; p++) begin
      frames(61, 0, 0, 0, 0);
      chk($sformatf("serve%0d bx", p), int'(dut.bx), 316);
      chk($sformatf("serve%0d by", p), int'(dut.by), 236);
      chk($sformatf("serve%0d state", p), int'(dut.state), 1);
      frames(79, 0, 0, 0, 0);
      chk($sformatf("pre p%0d score_l", p), int'(bus.score_l), p - 1);
      frames(1, 0, 0, 0, 0);
      chk($sformatf("p%0d score_l", p), int'(bus.score_l), p);
    end
    chk("win score_r", int'(bus.score_r), 0);
    frames(59, 0, 0, 0, 0);
    chk("pause game_over", int'(bus.game_over), 0);
    chk("pause state", int'(dut.state), 2);
    frames(1, 0, 0, 0, 0);
    chk("game_over", int'(bus.game_over), 1);
    chk("game_over state", int'(dut.state), 3);
    frames(3, 1, 0, 1, 0);
    chk("frozen bx", int'(dut.bx), 632);
    chk("frozen pl", int'(dut.pl), 208);
    chk("frozen pr", int'(dut.pr), 208);
    chk("frozen score_l", int'(bus.score_l), 9);
    pix("go background", 10'd100, 10'd100, 1'b0, 3'b100);
    pix("go net", 10'd318, 10'd0, 1'b0, 3'b011);
    pix("go paddle", 10'd20, 10'd210, 1'b0, 3'b111);
    pix("go blank", 10'd100, 10'd100, 1'b1, 3'b000);

    do_reset();
    chk_reset_state("rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
